sw_debounce_bist: RTL and testbench
===================================

# sw_debounce_bist

Switch front-end that sits directly upstream of the LED BIST stage. It synchronises and debounces the four raw board switches and drives the cleaned vector into the LED stage's `sw` input. It also runs an operator-driven switch self-test: after `start`, every switch must be seen to rise and then fall within a timeout window, and the block reports pass or fail.

## Interface
- `DEBOUNCE_CYCLES`, default 10: consecutive stable cycles required before `sw_clean` accepts a new value. Must be ≥1.
- `TIMEOUT_CYCLES`, default 100000000: length of the self-test window in clocks. Must be ≥2.

Ports:
- `clk` input, 1: single system clock. All logic is on the rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `sw_raw` input, 4: asynchronous, bouncy switch pins.
- `start` input, 1: single-cycle request to begin a self-test.
- `sw_clean` output, 4: debounced switch vector that feeds the LED BIST `sw` input.
- `busy` output, 1: high while a self-test is running.
- `seen` output, 4: per-switch flag, set once that switch has completed a debounced rise followed by a debounced fall during the test.
- `pass` output, 1: sticky; high after a successful test.
- `fail` output, 1: sticky; high after a timed-out test.

## Operation
- **Synchroniser:** two flops per bit, `s1 <= sw_raw` and `s2 <= s1`.
- **Debounce:** one counter per bit, width `$clog2(DEBOUNCE_CYCLES)+1`.
  - If `s2[i] == sw_clean[i]`, the counter is cleared to 0.
  - Otherwise, if the counter equals `DEBOUNCE_CYCLES-1`, then `sw_clean[i] <= s2[i]` and the counter is cleared.
  - Otherwise the counter increments.
- **Debounced edge events:** `rise[i]` and `fall[i]` are single-cycle pulses, derived from `sw_clean` and its one-cycle delayed copy.
- **Test FSM states:** IDLE, TEST, PASS, FAIL.
  - **IDLE:** `start` → TEST.
  - **TEST:** `busy=1`; a 32-bit timer increments each cycle; `start` is ignored.
    - `rise[i]` sets internal `armed[i]`.
    - `fall[i]` with `armed[i]=1` sets `seen[i]`.
    - A fall that arrives before any rise is ignored.
    - `seen==4'b1111` → PASS.
    - Timer `== TIMEOUT_CYCLES-1` with `seen!=4'b1111` → FAIL.
    - If completion and timeout occur in the same cycle, PASS wins.
  - **PASS / FAIL:** hold `pass` or `fail` and hold `seen`. `start` → TEST.
- **On every entry to TEST:** timer, `armed`, `seen`, `pass`, and `fail` are all cleared.
- **`sw_clean` is independent of the FSM:** it always follows debounced switch state, including during a test.

## Timing
- **Reset values:** all outputs 0 (`sw_clean=0000`, `busy=0`, `seen=0000`, `pass=0`, `fail=0`). Synchroniser flops, counters, and `armed` are all 0; state is IDLE.
- **Reset mid-operation:** an assertion in any state forces the reset values on the next edge. A `start` asserted in the first cycle after `rst` deasserts is accepted.
- **Debounce latency:** if a new level is first sampled into `s1` at edge R and then held, `sw_clean` changes at edge R+1+`DEBOUNCE_CYCLES` (11 edges with default D=10).
- **Glitch rejection:** any `s2` excursion shorter than `DEBOUNCE_CYCLES` cycles never reaches `sw_clean`.
- **Switches are independent:** simultaneous changes on several bits are debounced in parallel, and several `seen` bits may set in one cycle.
- **Start latency:** with `start` high at edge S in IDLE/PASS/FAIL, `busy=1` after edge S.
- **Completion latency:** `seen` updates on the edge after the `fall` pulse. `pass` and `busy=0` follow one edge after `seen` reaches 1111.
- **Timeout:** the timer is 0 on the first TEST cycle. FAIL is entered at the edge ending TEST cycle `TIMEOUT_CYCLES-1`, so `busy` is high for exactly `TIMEOUT_CYCLES` cycles.
- **`start` during TEST** has no effect: the timer is not restarted and `seen` is not cleared.

## Test plan
- **Clean edge** (D=10): `rst`, then `sw_raw` 0000→0101 held. `sw_clean`=0101 exactly 11 edges after the first sampling edge; bits 1 and 3 stay 0.
- **Bounce:** pulse `sw_raw[0]` high for 5 cycles, low for 3, high for 9, then low. `sw_clean` stays 0000 throughout.
- **Pass** (TIMEOUT=1000): pulse `start`, then raise and lower each switch in turn, 20 cycles per level. `seen` grows 0001→0011→0111→1111, then `pass=1`, `busy=0`, `fail=0`.
- **Fail plus fall-before-rise** (TIMEOUT=1000):
  - Hold `sw_raw[3]=1` until `sw_clean[3]=1`, then pulse `start`.
  - Lower `sw[3]`; exercise only `sw[0..2]` fully.
  - Required: `fail=1` after exactly 1000 busy cycles, `seen=0111`.
- **Restart:** from PASS, pulse `start`. `pass`, `fail`, and `seen` clear; `busy=1` on the next edge.
- **Reset mid-test:** assert `rst` for 1 cycle while `seen=0011`. Next edge shows all outputs 0, `sw_clean=0000`, state IDLE; a `start` pulse on the following cycle begins a fresh test.

Source files
------------

// File: rtl/sw_debounce_bist.sv
// Switch front-end: two-flop synchroniser and per-bit debounce feeding the LED BIST,
// plus an operator-driven self-test that checks each switch rises and falls within a window.
module sw_debounce_bist #(
    parameter int DEBOUNCE_CYCLES = 10,
    parameter int TIMEOUT_CYCLES  = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_raw,
    input  logic       start,
    output logic [3:0] sw_clean,
    output logic       busy,
    output logic [3:0] seen,
    output logic       pass,
    output logic       fail
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]   TMR_MAX = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_TEST, S_PASS, S_FAIL} state_t;

    logic [3:0]    s1, s2;
    logic [3:0]    sw_clean_d;
    logic [3:0]    rise, fall;
    logic [CW-1:0] cnt [4];

    state_t      state, state_n;
    logic [31:0] timer, timer_n;
    logic [3:0]  armed, armed_n;
    logic [3:0]  seen_n;

    // Synchroniser and debounce: a bit only follows s2 after it has differed for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= '0;
            s2         <= '0;
            sw_clean   <= '0;
            sw_clean_d <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            s1         <= sw_raw;
            s2         <= s1;
            sw_clean_d <= sw_clean;
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == sw_clean[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    sw_clean[i] <= s2[i];
                    cnt[i]      <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign rise = sw_clean & ~sw_clean_d;
    assign fall = ~sw_clean & sw_clean_d;

    // Self-test FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            timer <= '0;
            armed <= '0;
            seen  <= '0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            armed <= armed_n;
            seen  <= seen_n;
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        armed_n = armed;
        seen_n  = seen;
        case (state)
            S_IDLE, S_PASS, S_FAIL: begin
                if (start) begin
                    state_n = S_TEST;
                    timer_n = '0;
                    armed_n = '0;
                    seen_n  = '0;
                end
            end
            S_TEST: begin
                timer_n = timer + 32'd1;
                armed_n = armed | rise;
                // A fall only counts once the same switch has been seen rising in this test
                seen_n  = seen | (fall & armed);
                if (seen == 4'b1111)
                    state_n = S_PASS;
                else if (timer == TMR_MAX)
                    state_n = S_FAIL;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign busy = (state == S_TEST);
    assign pass = (state == S_PASS);
    assign fail = (state == S_FAIL);

endmodule

// File: tb/tb_sw_debounce_bist.sv
// Directed bench for sw_debounce_bist with DEBOUNCE_CYCLES=10 and TIMEOUT_CYCLES=1000.
module tb_sw_debounce_bist;

    localparam int D = 10;
    localparam int T = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw_raw;
    logic       start;
    logic [3:0] sw_clean;
    logic       busy;
    logic [3:0] seen;
    logic       pass;
    logic       fail;

    int vectors     = 0;
    int miscompares = 0;
    int busy_cyc    = 0;

    sw_debounce_bist #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .sw_raw(sw_raw), .start(start),
        .sw_clean(sw_clean), .busy(busy), .seen(seen), .pass(pass), .fail(fail)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (busy) busy_cyc++;
        end
    endtask

    task automatic exercise_sw(input int i);
        sw_raw[i] = 1'b1;
        tick(20);
        sw_raw[i] = 1'b0;
        tick(20);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sw_raw = 4'b0000; start = 1'b0;
        tick(2);
        vectors++;
        if ({sw_clean, busy, seen, pass, fail} !== 11'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want %b", {sw_clean, busy, seen, pass, fail}, 11'b0);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_clean_edge();
        sw_raw = 4'b0101;
        tick(11);
        vectors++;
        if (sw_clean !== 4'b0000) begin
            miscompares++;
            $display("FAIL clean_edge_early: got %b want %b", sw_clean, 4'b0000);
        end
        tick(1);
        vectors++;
        if (sw_clean !== 4'b0101) begin
            miscompares++;
            $display("FAIL clean_edge_at_11: got %b want %b", sw_clean, 4'b0101);
        end
        sw_raw = 4'b0000;
        tick(15);
        vectors++;
        if (sw_clean !== 4'b0000) begin
            miscompares++;
            $display("FAIL clean_edge_release: got %b want %b", sw_clean, 4'b0000);
        end
    endtask

    task automatic test_bounce();
        int   seg_len [4] = '{5, 3, 9, 15};
        logic seg_val [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int s = 0; s < 4; s++) begin
            sw_raw[0] = seg_val[s];
            for (int k = 0; k < seg_len[s]; k++) begin
                tick(1);
                vectors++;
                if (sw_clean !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL bounce seg%0d cyc%0d: got %b want %b", s, k, sw_clean, 4'b0000);
                end
            end
        end
    endtask

    task automatic test_pass();
        logic [3:0] exp_seen;
        pulse_start();
        vectors++;
        if (busy !== 1'b1 || seen !== 4'b0000) begin
            miscompares++;
            $display("FAIL pass_start: got busy=%b seen=%b want busy=1 seen=0000", busy, seen);
        end
        for (int i = 0; i < 3; i++) begin
            exercise_sw(i);
            exp_seen = 4'((1 << (i + 1)) - 1);
            vectors++;
            if (seen !== exp_seen || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL pass_seen_sw%0d: got seen=%b busy=%b want seen=%b busy=1", i, seen, busy, exp_seen);
            end
        end
        sw_raw[3] = 1'b1;
        tick(20);
        sw_raw[3] = 1'b0;
        tick(13);
        vectors++;
        if (seen !== 4'b1111 || busy !== 1'b1 || pass !== 1'b0) begin
            miscompares++;
            $display("FAIL pass_seen_full: got seen=%b busy=%b pass=%b want 1111 1 0", seen, busy, pass);
        end
        tick(1);
        vectors++;
        if (pass !== 1'b1 || busy !== 1'b0 || fail !== 1'b0) begin
            miscompares++;
            $display("FAIL pass_done: got pass=%b busy=%b fail=%b want 1 0 0", pass, busy, fail);
        end
        tick(5);
        vectors++;
        if (pass !== 1'b1 || seen !== 4'b1111) begin
            miscompares++;
            $display("FAIL pass_sticky: got pass=%b seen=%b want 1 1111", pass, seen);
        end
    endtask

    task automatic test_restart();
        pulse_start();
        vectors++;
        if ({busy, pass, fail, seen} !== 7'b1000000) begin
            miscompares++;
            $display("FAIL restart: got %b want %b", {busy, pass, fail, seen}, 7'b1000000);
        end
    endtask

    task automatic test_fail();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        sw_raw = 4'b1000;
        tick(12);
        vectors++;
        if (sw_clean !== 4'b1000) begin
            miscompares++;
            $display("FAIL fail_pre_hold: got %b want %b", sw_clean, 4'b1000);
        end
        busy_cyc = 0;
        pulse_start();
        sw_raw = 4'b0000;
        tick(20);
        vectors++;
        if (sw_clean !== 4'b0000 || seen !== 4'b0000) begin
            miscompares++;
            $display("FAIL fall_before_rise: got clean=%b seen=%b want 0000 0000", sw_clean, seen);
        end
        for (int i = 0; i < 3; i++) exercise_sw(i);
        pulse_start();
        vectors++;
        if (seen !== 4'b0111 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL start_in_test: got seen=%b busy=%b want 0111 1", seen, busy);
        end
        for (int k = 0; k < 1500 && busy; k++) tick(1);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_wait: got busy=%b want 0 within budget", busy);
        end
        vectors++;
        if (busy_cyc !== T) begin
            miscompares++;
            $display("FAIL busy_cycles: got %0d want %0d", busy_cyc, T);
        end
        vectors++;
        if (fail !== 1'b1 || pass !== 1'b0 || seen !== 4'b0111) begin
            miscompares++;
            $display("FAIL fail_result: got fail=%b pass=%b seen=%b want 1 0 0111", fail, pass, seen);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        exercise_sw(0);
        exercise_sw(1);
        sw_raw = 4'b0100;
        tick(15);
        vectors++;
        if (seen !== 4'b0011 || sw_clean !== 4'b0100 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre: got seen=%b clean=%b busy=%b want 0011 0100 1", seen, sw_clean, busy);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        vectors++;
        if ({sw_clean, busy, seen, pass, fail} !== 11'b0) begin
            miscompares++;
            $display("FAIL mid_reset: got %b want %b", {sw_clean, busy, seen, pass, fail}, 11'b0);
        end
        pulse_start();
        vectors++;
        if ({busy, pass, fail, seen} !== 7'b1000000) begin
            miscompares++;
            $display("FAIL mid_restart: got %b want %b", {busy, pass, fail, seen}, 7'b1000000);
        end
        tick(19);
        sw_raw = 4'b0000;
        tick(20);
        vectors++;
        if (seen !== 4'b0100 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_fresh_seen: got seen=%b busy=%b want 0100 1", seen, busy);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_clean_edge();
        test_bounce();
        test_pass();
        test_restart();
        test_fail();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
